dmem_responder: RTL and testbench

Multi-cycle responder for the CPU data-memory port: accepts one load or store request at a time over a Req/Ready handshake, inserts a fixed number of wait states, then completes the access and returns read data. It sits between the datapath's ALU result / Qb store path and a word-addressed data array. It replaces the zero-latency combinational data memory when the core runs against a slower memory model.

---
 rtl/dmem_responder_pkg.sv | 14 +
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 117 +++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM state encoding, default array depth and wait-counter width.
package dmem_responder_pkg;

  localparam int DEPTH_LOG2_DEF = 6;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: synchronous write port, combinational read port.
// Contents are deliberately not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  Clk,
  input  logic                  We,
  input  logic [DEPTH_LOG2-1:0] Wa,
  input  logic [31:0]           Wd,
  input  logic [DEPTH_LOG2-1:0] Ra,
  output logic [31:0]           Rd
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge Clk) begin
    if (We) mem[Wa] <= Wd;
  end

  assign Rd = mem[Ra];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store over Req, waits WAIT cycles,
// executes the access and pulses Ready with registered Dout/Err.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int WAIT       = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wmem,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  output logic        Ready,
  output logic [31:0] Dout,
  output logic        Busy,
  output logic        Err
);

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT);
  localparam int               AW      = DEPTH_LOG2 + 2;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    lat_addr;
  logic [31:0]      lat_din;
  logic             lat_wmem;

  logic [AW-1:0]         acc_addr;
  logic [31:0]           acc_din;
  logic                  acc_wmem;
  logic                  acc_mis;
  logic                  do_exec;
  logic                  we;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [31:0]           rd;
  logic                  addr_unused;

  assign addr_unused = ^Addr[31:AW];

  // With WAIT=0 the access executes on the accept edge itself, so the
  // array port is fed from the live inputs while idle.
  always_comb begin
    acc_addr = lat_addr;
    acc_din  = lat_din;
    acc_wmem = lat_wmem;
    do_exec  = 1'b0;
    if (state == ST_IDLE) begin
      acc_addr = Addr[AW-1:0];
      acc_din  = Din;
      acc_wmem = Wmem;
      do_exec  = Req && (WAIT == 0);
    end else if (state == ST_WAIT) begin
      do_exec = (cnt == CNT_W'(1));
    end
  end

  assign acc_mis = (acc_addr[1:0] != 2'b00);
  assign acc_idx = acc_addr[AW-1:2];
  assign we      = do_exec && acc_wmem && !acc_mis && Reset;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .Clk (Clk),
    .We  (we),
    .Wa  (acc_idx),
    .Wd  (acc_din),
    .Ra  (acc_idx),
    .Rd  (rd)
  );

  // Execution overrides the per-state updates so the WAIT=0 accept edge
  // goes straight to RESP with the access result.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_din  <= '0;
      lat_wmem <= 1'b0;
      Ready    <= 1'b0;
      Busy     <= 1'b0;
      Err      <= 1'b0;
      Dout     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          Ready <= 1'b0;
          if (Req) begin
            lat_addr <= Addr[AW-1:0];
            lat_din  <= Din;
            lat_wmem <= Wmem;
            cnt      <= WAIT_LD;
            Busy     <= 1'b1;
            Err      <= 1'b0;
            Dout     <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: cnt <= cnt - CNT_W'(1);
        ST_RESP: begin
          Ready <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (do_exec) begin
        Ready <= 1'b1;
        Err   <= acc_mis;
        Dout  <= (acc_mis || acc_wmem) ? 32'd0 : rd;
        state <= ST_RESP;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: instance 0 runs WAIT=2, instance 1
// runs WAIT=0; a per-cycle monitor checks Busy/Ready/Dout/Err against a queue.
module tb_dmem_responder;

  typedef struct {
    int          dut;
    logic [31:0] dout;
    logic        err;
    int          rdy_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n [2] = '{1'b1, 1'b1};
  logic        req   [2] = '{1'b0, 1'b0};
  logic        wmem  [2] = '{1'b0, 1'b0};
  logic [31:0] addr  [2] = '{32'd0, 32'd0};
  logic [31:0] din   [2] = '{32'd0, 32'd0};
  logic        ready [2];
  logic [31:0] dout  [2];
  logic        busy  [2];
  logic        err   [2];

  exp_t        sb[$];
  logic [31:0] mem [2][64];
  logic [31:0] hold_dout [2] = '{32'd0, 32'd0};
  logic        hold_err  [2] = '{1'b0, 1'b0};
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_LOG2(6), .WAIT(2)) u0 (
    .Clk(clk), .Reset(rst_n[0]), .Req(req[0]), .Wmem(wmem[0]), .Addr(addr[0]),
    .Din(din[0]), .Ready(ready[0]), .Dout(dout[0]), .Busy(busy[0]), .Err(err[0])
  );

  dmem_responder #(.DEPTH_LOG2(6), .WAIT(0)) u1 (
    .Clk(clk), .Reset(rst_n[1]), .Req(req[1]), .Wmem(wmem[1]), .Addr(addr[1]),
    .Din(din[1]), .Ready(ready[1]), .Dout(dout[1]), .Busy(busy[1]), .Err(err[1])
  );

  function automatic int waitOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour: word index is the byte address divided by 4, modulo 64.
  task automatic pushModel(input int d, input logic w, input logic [31:0] a, input logic [31:0] di);
    exp_t e;
    int   idx;
    idx       = int'((a / 4) % 64);
    e.dut     = d;
    e.rdy_cyc = cyc + waitOf(d);
    if (a % 4 != 0) begin
      e.err = 1'b1; e.dout = 32'd0;
    end else if (w) begin
      mem[d][idx] = di; e.err = 1'b0; e.dout = 32'd0;
    end else begin
      e.err = 1'b0; e.dout = mem[d][idx];
    end
    sb.push_back(e);
  endtask

  task automatic monitorStep(input int d);
    int hit;
    hit = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].dut == d) begin hit = i; break; end
    end
    checkOutput($sformatf("busy%0d", d), {31'd0, busy[d]}, (hit >= 0) ? 32'd1 : 32'd0);
    if (ready[d] === 1'b1) begin
      if (hit < 0) begin
        checkOutput($sformatf("unexpected_ready%0d", d), 32'd1, 32'd0);
      end else begin
        checkOutput($sformatf("ready_cycle%0d", d), cyc, sb[hit].rdy_cyc);
        checkOutput($sformatf("dout%0d", d), dout[d], sb[hit].dout);
        checkOutput($sformatf("err%0d", d), {31'd0, err[d]}, {31'd0, sb[hit].err});
        hold_dout[d] = sb[hit].dout;
        hold_err[d]  = sb[hit].err;
        sb.delete(hit);
      end
    end else if (hit >= 0) begin
      if (cyc >= sb[hit].rdy_cyc) begin
        checkOutput($sformatf("ready_missing%0d", d), 32'd0, 32'd1);
        sb.delete(hit);
      end
    end else begin
      checkOutput($sformatf("hold_dout%0d", d), dout[d], hold_dout[d]);
      checkOutput($sformatf("hold_err%0d", d), {31'd0, err[d]}, {31'd0, hold_err[d]});
    end
  endtask

  always @(negedge clk) begin
    monitorStep(0);
    monitorStep(1);
  end

  task automatic waitIdle(input int d);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy[d] !== 1'b0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one request, then optionally scribble inputs until Ready.
  task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                               input logic [31:0] di, input bit scribble);
    int guard;
    waitIdle(d);
    req[d] = 1'b1; wmem[d] = w; addr[d] = a; din[d] = di;
    @(posedge clk); #1;
    pushModel(d, w, a, di);
    guard = 0;
    forever begin
      @(negedge clk);
      if (ready[d] === 1'b1 || guard > 40) begin
        req[d] = 1'b0;
        break;
      end
      if (scribble) begin
        req[d]  = 1'($urandom_range(0, 1));
        wmem[d] = 1'($urandom_range(0, 1));
        addr[d] = $urandom;
        din[d]  = $urandom;
      end
      guard++;
    end
  endtask

  initial begin
    logic [31:0] a;
    #1;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h13, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'h13, 32'hCAFEF00D, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b0);

    for (int i = 0; i < 64; i++) applyStimulus(0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    applyStimulus(0, 1'b1, 32'h20, 32'h1, 1'b1);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'h100, 32'h5A, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      applyStimulus(0, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset during WAIT of a store: the store must be dropped.
    waitIdle(0);
    req[0] = 1'b1; wmem[0] = 1'b1; addr[0] = 32'h40; din[0] = 32'h55;
    @(posedge clk); #1;
    sb.push_back('{dut: 0, dout: 32'd0, err: 1'b0, rdy_cyc: cyc + 2});
    @(negedge clk);
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].dut == 0) sb.delete(i);
    hold_dout[0] = 32'd0; hold_err[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n[0] = 1'b1;
    applyStimulus(0, 1'b0, 32'h40, 32'h0, 1'b0);

    // WAIT=0 instance with Req held high across two stores.
    waitIdle(1);
    req[1] = 1'b1; wmem[1] = 1'b1; addr[1] = 32'h4; din[1] = 32'h1;
    @(posedge clk); #1;
    pushModel(1, 1'b1, 32'h4, 32'h1);
    @(negedge clk);
    addr[1] = 32'h8; din[1] = 32'h2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pushModel(1, 1'b1, 32'h8, 32'h2);
    @(negedge clk);
    req[1] = 1'b0;
    applyStimulus(1, 1'b0, 32'h4, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h8, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 32'h7, 32'h0, 1'b0);

    repeat (8) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
